// File: rtl/vmem_pkg.sv
// Shared types and constants for the vmem write path.
package vmem_pkg;

  localparam int unsigned SCREEN_W    = 240;
  localparam int unsigned SCREEN_H    = 240;
  localparam int unsigned VMEM_ADDR_W = 16;
  localparam int unsigned PIX_W       = 16;

  // grant_id width and per-grant beat counter width
  localparam int unsigned GID_W  = 3;
  localparam int unsigned BEAT_W = 8;

  localparam logic [PIX_W-1:0] COL_BACKGROUND = 16'h07FF;
  localparam logic [PIX_W-1:0] COL_JUDGE_LINE = 16'hFF00;
  localparam logic [PIX_W-1:0] COL_MAGENTA    = 16'hF81F;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FILL
  } arb_state_t;

endpackage

// File: rtl/vmem_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit strictly after ptr, wrapping modulo N.
module rr_pick
  import vmem_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] winner,
  output logic             any_valid
);

  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] idx;

  // scan ptr+1 .. ptr+N; the first hit wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = SW'((32'(ptr) + k) % N);
      if (!any_valid && req[idx]) begin
        winner    = GID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_wr_arbiter.sv
// Round-robin arbiter sharing the vmem write port among NREQ pixel producers.
// Optional full-screen fill engine: define VMEM_ARB_FILL_EN.
module vmem_wr_arbiter
  import vmem_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                   w_clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   vm_we,
  output logic [ADDR_W-1:0]      vm_waddr,
  output logic [DATA_W-1:0]      vm_wdata,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy
`ifdef VMEM_ARB_FILL_EN
  ,
  input  logic                   fill_start,
  input  logic [DATA_W-1:0]      fill_color,
  output logic                   fill_busy
`endif
);

  arb_state_t        state, state_nxt;
  logic [GID_W-1:0]  rr_ptr;
  logic [GID_W-1:0]  pick_id;
  logic              pick_any;
  logic [BEAT_W-1:0] beat_cnt;

  logic              cur_valid;
  logic              cur_last;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              xfer;
  logic              burst_end;
  logic              grant_exit;
  logic              fill_req;

  rr_pick #(.N(NREQ)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

  // select the current grantee's stream
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_addr  = '0;
    cur_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_addr  = req_addr[i*ADDR_W +: ADDR_W];
        cur_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer       = (state == GRANT) && cur_valid;
  assign burst_end  = xfer && (cur_last || (beat_cnt == BEAT_W'(BURST_MAX - 1)));
  assign grant_exit = (state == GRANT) && (!cur_valid || burst_end);

`ifdef VMEM_ARB_FILL_EN
  logic              fill_pend;
  logic [DATA_W-1:0] fill_col;
  logic [7:0]        fill_x;
  logic [7:0]        fill_y;
  logic              fill_done;

  assign fill_req  = fill_pend;
  assign fill_done = (fill_x == 8'(SCREEN_W - 1)) && (fill_y == 8'(SCREEN_H - 1));

  // fill request latch and raster counters (x inner, y outer)
  always_ff @(posedge w_clk or negedge rstn) begin
    if (!rstn) begin
      fill_pend <= 1'b0;
      fill_col  <= '0;
      fill_x    <= '0;
      fill_y    <= '0;
    end else begin
      if ((state == IDLE) && fill_pend) begin
        fill_pend <= 1'b0;
      end else if (fill_start && (state != FILL)) begin
        fill_pend <= 1'b1;
        fill_col  <= fill_color;
      end
      if (state == FILL) begin
        if (fill_x == 8'(SCREEN_W - 1)) begin
          fill_x <= '0;
          fill_y <= fill_done ? '0 : fill_y + 1'b1;
        end else begin
          fill_x <= fill_x + 1'b1;
        end
      end
    end
  end
`else
  assign fill_req = 1'b0;
`endif

  // state register
  always_ff @(posedge w_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fill_req)      state_nxt = FILL;
        else if (pick_any) state_nxt = GRANT;
      end
      GRANT: begin
        if (grant_exit) state_nxt = IDLE;
      end
`ifdef VMEM_ARB_FILL_EN
      FILL: begin
        if (fill_done) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if ((state == GRANT) && (grant_id == GID_W'(i))) req_ready[i] = 1'b1;
    end
    busy = (state != IDLE);
`ifdef VMEM_ARB_FILL_EN
    fill_busy = (state == FILL);
`endif
  end

  // grant bookkeeping and registered write port
  always_ff @(posedge w_clk or negedge rstn) begin
    if (!rstn) begin
      grant_id <= '0;
      rr_ptr   <= GID_W'(NREQ - 1);
      beat_cnt <= '0;
      vm_we    <= 1'b0;
      vm_waddr <= '0;
      vm_wdata <= '0;
    end else begin
      vm_we <= 1'b0;
      if ((state == IDLE) && !fill_req && pick_any) begin
        grant_id <= pick_id;
        beat_cnt <= '0;
      end
      if (xfer) begin
        vm_we    <= 1'b1;
        vm_waddr <= cur_addr;
        vm_wdata <= cur_data;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (grant_exit) rr_ptr <= grant_id;
`ifdef VMEM_ARB_FILL_EN
      if (state == FILL) begin
        vm_we    <= 1'b1;
        vm_waddr <= ADDR_W'({fill_y, fill_x});
        vm_wdata <= fill_col;
      end
`endif
    end
  end

endmodule

// File: tb/tb_vmem_wr_arbiter.sv
// Bench for vmem_wr_arbiter: directed phases plus a random phase, checked against a
// transaction-level reference model. Fill scenario included when VMEM_ARB_FILL_EN is defined.
module tb_vmem_wr_arbiter;

  localparam int NREQ = 4;
  localparam int BMAX = 8;
  localparam int SZ   = 256;

  logic             w_clk = 1'b0;
  logic             rstn  = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  req_last = '0;
  logic [NREQ*16-1:0] req_addr = '0;
  logic [NREQ*16-1:0] req_data = '0;
  logic             vm_we;
  logic [15:0]      vm_waddr;
  logic [15:0]      vm_wdata;
  logic [2:0]       grant_id;
  logic             busy;
`ifdef VMEM_ARB_FILL_EN
  logic             fill_start = 1'b0;
  logic [15:0]      fill_color = '0;
  logic             fill_busy;
`endif

  vmem_wr_arbiter #(
    .NREQ      (NREQ),
    .ADDR_W    (16),
    .DATA_W    (16),
    .BURST_MAX (BMAX)
  ) dut (
    .w_clk     (w_clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .vm_we     (vm_we),
    .vm_waddr  (vm_waddr),
    .vm_wdata  (vm_wdata),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef VMEM_ARB_FILL_EN
    ,
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fill_busy (fill_busy)
`endif
  );

  always #5 w_clk = ~w_clk;

  int tests = 0;
  int fails = 0;

  // producer beat queues (ring buffers)
  logic [15:0] pa [NREQ][SZ];
  logic [15:0] pd [NREQ][SZ];
  bit          pl [NREQ][SZ];
  int          phead [NREQ];
  int          ptail [NREQ];
  bit          hold  [NREQ];
  int          acc   [NREQ];
  int          seqn  [NREQ];

  // reference model: owner = -1 while arbitrating
  int          m_owner;
  int          m_last;
  int          m_beats;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  logic [2:0]  m_gid;

  logic [15:0] seen_d [$];
  logic [15:0] seen_a [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [15:0] a, input bit l);
    pa[r][ptail[r] % SZ] = a;
    pd[r][ptail[r] % SZ] = {4'(r), 12'(seqn[r])};
    pl[r][ptail[r] % SZ] = l;
    seqn[r]++;
    ptail[r]++;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (phead[i] != ptail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if ((phead[i] != ptail[i]) && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_addr[i*16 +: 16]  = pa[i][phead[i] % SZ];
        req_data[i*16 +: 16]  = pd[i][phead[i] % SZ];
        req_last[i]           = pl[i][phead[i] % SZ];
      end else begin
        req_valid[i]          = 1'b0;
        req_addr[i*16 +: 16]  = 16'($urandom);
        req_data[i*16 +: 16]  = 16'($urandom);
        req_last[i]           = 1'($urandom);
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_beats = 0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_gid   = '0;
  endtask

  task automatic model_step();
    int  i;
    int  o;
    bit  fin;
    if (m_owner < 0) begin
      m_we = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (m_owner < 0 && req_valid[i]) begin
          m_owner = i;
          m_gid   = 3'(i);
          m_beats = 0;
        end
      end
    end else if (req_valid[m_owner]) begin
      o      = m_owner;
      m_we   = 1'b1;
      m_addr = pa[o][phead[o] % SZ];
      m_data = pd[o][phead[o] % SZ];
      fin    = pl[o][phead[o] % SZ];
      phead[o]++;
      acc[o]++;
      m_beats++;
      if (fin || m_beats == BMAX) begin
        m_last  = o;
        m_owner = -1;
      end
    end else begin
      m_we    = 1'b0;
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  task automatic compare_outputs();
    logic [NREQ-1:0] er;
    for (int i = 0; i < NREQ; i++) er[i] = (m_owner == i);
    chk("vm_we", vm_we, m_we);
    chk("vm_waddr", vm_waddr, m_addr);
    chk("vm_wdata", vm_wdata, m_data);
    chk("req_ready", req_ready, er);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_owner >= 0);
  endtask

  task automatic cycle();
    drive();
    @(negedge w_clk);
    compare_outputs();
    if (vm_we === 1'b1) begin
      seen_d.push_back(vm_wdata);
      seen_a.push_back(vm_waddr);
    end
    model_step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = ptail[i];
      hold[i]  = 1'b0;
      acc[i]   = 0;
    end
    drive();
    model_reset();
    @(negedge w_clk);
    compare_outputs();
    @(posedge w_clk);
    #1;
    rstn = 1'b1;
    seen_d.delete();
    seen_a.delete();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((pending() || m_owner >= 0 || m_we) && n < limit) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_in_budget"}, n < limit, 1'b1);
    cycle();
    cycle();
  endtask

  task automatic chk_seq(input string tag, input logic [15:0] exp [$]);
    chk({tag, "_count"}, seen_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen_d.size(); i++) chk({tag, "_data"}, seen_d[i], exp[i]);
  endtask

  initial begin
    logic [15:0] ex [$];
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0; ptail[i] = 0; hold[i] = 0; acc[i] = 0; seqn[i] = 0;
    end
    model_reset();
    #2;

    // reset values
    do_reset();

    // single requester 2, 3-beat burst
    for (int b = 0; b < 3; b++) push(2, 16'(b), b == 2);
    drain("p1", 50);
    ex = {16'h2000, 16'h2001, 16'h2002};
    chk_seq("p1", ex);
    for (int i = 0; i < 3 && i < seen_a.size(); i++) chk("p1_addr", seen_a[i], 16'(i));

    // all four requesters, single-beat bursts: strict rotation
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NREQ; r++) push(r, 16'($urandom), 1'b1);
    for (int r = 0; r < NREQ; r++) seqn[r] = seqn[r];
    drain("p2", 100);
    ex.delete();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NREQ; r++) ex.push_back(pd[r][(ptail[r] - 2 + b) % SZ]);
    chk_seq("p2", ex);

    // req1 streams 20 beats without last, req3 one 4-beat burst: forced rotation at BMAX
    do_reset();
    seqn[1] = 0; seqn[3] = 0;
    for (int b = 0; b < 20; b++) push(1, 16'($urandom), 1'b0);
    for (int b = 0; b < 4; b++) push(3, 16'($urandom), b == 3);
    drain("p3", 200);
    ex.delete();
    for (int b = 0; b < 8; b++)   ex.push_back(16'h1000 + 16'(b));
    for (int b = 0; b < 4; b++)   ex.push_back(16'h3000 + 16'(b));
    for (int b = 8; b < 20; b++)  ex.push_back(16'h1000 + 16'(b));
    chk_seq("p3", ex);

    // grantee 2 drops valid after 2 beats; next arbitration starts at 3
    do_reset();
    seqn[0] = 0; seqn[2] = 0; seqn[3] = 0;
    push(0, 16'h0100, 1'b1);
    for (int b = 0; b < 4; b++) push(2, 16'h0200 + 16'(b), b == 3);
    for (int b = 0; b < 2; b++) push(3, 16'h0300 + 16'(b), b == 1);
    begin
      int n = 0;
      while ((pending() || m_owner >= 0 || m_we) && n < 100) begin
        hold[2] = (acc[2] >= 2) && (acc[3] < 2);
        cycle();
        n++;
      end
      chk("p4_drain_in_budget", n < 100, 1'b1);
      hold[2] = 1'b0;
      cycle();
    end
    ex = {16'h0000, 16'h2000, 16'h2001, 16'h3000, 16'h3001, 16'h2002, 16'h2003};
    chk_seq("p4", ex);

    // async reset in the middle of a req0 burst
    do_reset();
    seqn[0] = 0; seqn[1] = 0;
    for (int b = 0; b < 6; b++) push(0, 16'h0400 + 16'(b), b == 5);
    cycle();
    cycle();
    cycle();
    #2;
    rstn = 1'b0;
    #1;
    chk("p5_async_vm_we", vm_we, 1'b0);
    chk("p5_async_ready", req_ready, 4'b0000);
    chk("p5_async_busy", busy, 1'b0);
    model_reset();
    seen_d.delete();
    seen_a.delete();
    @(posedge w_clk);
    #1;
    rstn = 1'b1;
    for (int b = 0; b < 2; b++) push(1, 16'h0500 + 16'(b), b == 1);
    drain("p5", 60);
    ex = {16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h1000, 16'h1001};
    chk_seq("p5", ex);

    // random traffic with random stalls
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (($urandom % 3 == 0) && (ptail[r] - phead[r] < 12))
          push(r, 16'($urandom), ($urandom % 4) == 0);
        hold[r] = ($urandom % 8) == 0;
      end
      cycle();
    end
    for (int r = 0; r < NREQ; r++) hold[r] = 1'b0;
    drain("p6", 500);

`ifdef VMEM_ARB_FILL_EN
    // fill requested while req0 is mid-burst
    do_reset();
    seqn[0] = 0;
    for (int b = 0; b < 8; b++) push(0, 16'h0600 + 16'(b), (b % 4) == 3);
    begin
      int n = 0, fcnt = 0, ferr = 0, pre = 0, bad_ready = 0;
      bit pop0, saw_busy = 1'b0;
      logic [15:0] last_a = '0, ea;
      drive();
      while (fcnt < 57600 && n < 60000) begin
        @(negedge w_clk);
        if (vm_we === 1'b1) begin
          if (vm_wdata === 16'hF81F) begin
            ea = {8'(fcnt / 240), 8'(fcnt % 240)};
            if (vm_waddr !== ea) ferr++;
            last_a = vm_waddr;
            fcnt++;
          end else if (fcnt == 0) begin
            pre++;
          end
        end
        if (fill_busy === 1'b1) begin
          saw_busy = 1'b1;
          if (req_ready !== '0) bad_ready++;
        end
        pop0 = req_valid[0] && req_ready[0];
        @(posedge w_clk);
        #1;
        if (pop0) phead[0]++;
        fill_start = (n == 2);
        fill_color = 16'hF81F;
        drive();
        n++;
      end
      fill_start = 1'b0;
      chk("fill_write_count", fcnt, 57600);
      chk("fill_addr_order_errs", ferr, 0);
      chk("fill_last_addr", last_a, 16'hEFEF);
      chk("fill_req0_beats_before", pre, 4);
      chk("fill_ready_during_fill", bad_ready, 0);
      chk("fill_busy_seen", saw_busy, 1'b1);
      @(negedge w_clk);
      chk("fill_busy_after", fill_busy, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vmem_wr_arbiter.md
Name: vmem_wr_arbiter

Overview:
- Round-robin arbiter that shares the single frame-buffer (video memory) write port among NREQ independent pixel producers, e.g. playfield renderer, score/meter overlay, note sprites.
- Each requester uses a valid/ready stream with an optional burst `last` marker.
- The winner holds the port for up to BURST_MAX beats.
- Sits between the producers and the 240x240 vmem write port, which the ST7789 refresh path reads.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 16, vmem address width ({y[7:0], x[7:0]})
- DATA_W, 16, pixel width (RGB565)
- BURST_MAX, 8, maximum beats per grant before forced rotation (1..255)

Ports:
- w_clk  in  1  main clock (100 MHz)
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester beat valid
- req_ready  out  NREQ  per-requester beat accepted
- req_last  in  NREQ  final beat of burst
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed pixels, same packing
- vm_we  out  1  vmem write enable
- vm_waddr  out  ADDR_W  vmem write address
- vm_wdata  out  DATA_W  vmem write data
- grant_id  out  3  index of current/last grantee
- busy  out  1  high while in GRANT (or FILL)

Behaviour:
- Reset (async, rstn=0): state=IDLE, vm_we=0, vm_waddr=0, vm_wdata=0, grant_id=0, req_ready=0, beat_cnt=0, rr_ptr=NREQ-1, so requester 0 has first priority.
- States: IDLE, GRANT (plus FILL when the optional feature is enabled).
- IDLE:
  - If any req_valid, pick the first valid index searching from rr_ptr+1 upward, modulo NREQ.
  - Register it into grant_id; go to GRANT; beat_cnt=0.
  - No beat is accepted in IDLE; arbitration costs 1 cycle.
- GRANT:
  - req_ready[grant_id]=1 (decoded from registered state, no combinational path from req_valid); all other ready bits 0.
  - Beat transfers on an edge with valid&ready.
  - Transferred addr/data are registered onto vm_waddr/vm_wdata with vm_we=1 on the following cycle (1-cycle latency).
  - vm_we=0 in any cycle after no transfer; vm_waddr/vm_wdata hold their last value.
- GRANT exit (go to IDLE, rr_ptr<=grant_id) on the first of:
  - transfer with req_last=1;
  - transfer that makes beat_cnt reach BURST_MAX;
  - req_valid[grant_id]=0 (grantee stalls or drops; 0 beats counted for that cycle).
- Simultaneous requests: strict rotation. After requester k is served, k has lowest priority at the next arbitration.
- A single requester alone is regranted after 1 idle cycle, giving sustained throughput of BURST_MAX/(BURST_MAX+1).
- Async reset mid-burst: immediate return to reset values. An in-flight registered write is dropped (vm_we=0).
- req_addr/req_data of non-granted requesters are ignored.
- No address range checking; values pass through unmodified.

Optional Feature:
- Macro: VMEM_ARB_FILL_EN.
- Enabled:
  - Adds ports fill_start (in,1), fill_color (in,DATA_W), fill_busy (out,1, reset 0).
  - A fill_start pulse is latched with fill_color.
  - The fill is taken from IDLE with priority over all requesters, so it waits for the current burst to end.
  - FILL writes one pixel per cycle: x 0..239 inner, y 0..239 outer, address {y,x}; 57600 beats.
  - During FILL all req_ready=0, busy=1, fill_busy=1.
  - After writing {239,239}, return to IDLE; rr_ptr unchanged.
  - fill_start during FILL is ignored; a pending start is cleared by reset.
- Disabled: ports absent; FILL state and counters not generated.

Decomposition:
- Shared package vmem_pkg holds:
  - SCREEN_W=240, SCREEN_H=240, VMEM_ADDR_W=16, PIX_W=16;
  - arb_state_t enum {IDLE, GRANT, FILL};
  - colour constants used by the game, e.g. 16'h07FF background, 16'hFF00 judge line.
- One natural sub-module: rr_pick, a combinational round-robin first-one search.
  - Inputs: req vector, rr_ptr. Outputs: winner index, any_valid.
  - Reusable by a future SPI command scheduler.

Test Plan:
- Single requester 2, 3-beat burst (addrs 0x0000/0x0001/0x0002, last on 3rd):
  - grant_id=2 one cycle after valid;
  - vm_we high 3 consecutive cycles, one cycle after each accept, with matching addr/data;
  - then IDLE.
- All 4 requesters valid, continuous single-beat (last=1): grant order 0,1,2,3,0,1; exactly one beat each; idle cycle between grants.
- Requester 1 streams 20 beats, last never asserted, BURST_MAX=8; requester 3 also valid:
  - req1 gets 8 beats, then req3 gets its burst, then req1 resumes;
  - no lost or duplicated beat (checked against a scoreboard).
- Grantee drops valid after 2 beats: return to IDLE; next arbitration starts from grantee+1; vm_we low for the dropped cycles.
- Assert rstn=0 mid-burst for 1 cycle: vm_we=0 and req_ready=0 immediately (async); after release, requester 0 wins first.
- With VMEM_ARB_FILL_EN, fill_start with fill_color=16'hF81F while requester 0 is mid-burst:
  - fill begins after req0's burst ends;
  - 57600 writes, the last at 0xEFEF;
  - fill_busy deasserts;
  - req0 is refused throughout the fill.
